fetch_pc_unit: RTL and testbench

Instruction-fetch stage of the single-cycle CPU: owns the program counter, fetches one instruction word from instruction memory over a req/ack handshake, and holds it for the decode/execute path (main control decoder, register file, ALU) until that path signals completion. On completion it selects the next PC from the decoder's jump/branch outputs and the ALU zero flag: sequential, taken branch, J/JAL target, or JR register target.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/next_pc_calc.sv | 43 ++++
 rtl/fetch_pc_unit.sv | 120 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, jump encodings and the fetch state enum.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] JUMP_J   = 2'b00;
  localparam logic [1:0] JUMP_SEQ = 2'b01;
  localparam logic [1:0] JUMP_JR  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: JR, J/JAL, taken branch, or sequential.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [25:0]     instr_idx_i,
  input  logic [1:0]      jump_i,
  input  logic            branch_i,
  input  logic            branch_type_i,
  input  logic            zero_i,
  input  logic [XLEN-1:0] rs_data_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            taken_o
);

  logic            br_taken;
  logic [XLEN-1:0] br_off;

  always_comb begin
    br_taken  = branch_i && (branch_type_i ? zero_i : !zero_i);
    br_off    = {{14{instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
    next_pc_o = pc_plus4_i;
    taken_o   = 1'b0;
    case (jump_i)
      JUMP_JR: begin
        // Misaligned register targets are silently truncated.
        next_pc_o = rs_data_i & ~32'd3;
        taken_o   = 1'b1;
      end
      JUMP_J: begin
        next_pc_o = {pc_plus4_i[31:28], instr_idx_i, 2'b00};
        taken_o   = 1'b1;
      end
      default: begin
        if (br_taken) begin
          next_pc_o = pc_plus4_i + br_off;
          taken_o   = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC, imem req/ack fetch and instruction hold until execute completes.
// Optional FETCH_PERF_EN adds retired/taken counters.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] instr_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  input  logic [1:0]      jump_i,
  input  logic            branch_i,
  input  logic            branch_type_i,
  input  logic            zero_i,
`ifdef FETCH_PERF_EN
  output logic [31:0]     retired_cnt_o,
  output logic [31:0]     taken_cnt_o,
`endif
  input  logic [XLEN-1:0] rs_data_i
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            req_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            taken;
  logic            accept;

  assign pc_plus4      = pc_q + 32'd4;
  assign accept        = (state_q == StHold) && instr_ready_i;
  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4_i    (pc_plus4),
    .instr_idx_i   (instr_q[25:0]),
    .jump_i        (jump_i),
    .branch_i      (branch_i),
    .branch_type_i (branch_type_i),
    .zero_i        (zero_i),
    .rs_data_i     (rs_data_i),
    .next_pc_o     (next_pc),
    .taken_o       (taken)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StFetch;
          req_q   <= 1'b1;
        end
        StFetch: begin
          if (imem_ack_i) begin
            instr_q <= imem_data_i;
            state_q <= StHold;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (instr_ready_i) begin
            pc_q    <= next_pc;
            state_q <= StFetch;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] taken_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else if (accept) begin
      retired_q <= retired_q + 32'd1;
      if (taken) taken_q <= taken_q + 32'd1;
    end
  end

  assign retired_cnt_o = retired_q;
  assign taken_cnt_o   = taken_q;
`else
  logic unused_perf;
  assign unused_perf = accept ^ taken;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: table of instructions chained through the PC,
// plus wait-state and mid-fetch reset sequences.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [1:0]  jump_i;
  logic        branch_i;
  logic        branch_type_i;
  logic        zero_i;
  logic [31:0] rs_data_i;
`ifdef FETCH_PERF_EN
  logic [31:0] retired_cnt_o;
  logic [31:0] taken_cnt_o;
`endif

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .jump_i        (jump_i),
    .branch_i      (branch_i),
    .branch_type_i (branch_type_i),
    .zero_i        (zero_i),
`ifdef FETCH_PERF_EN
    .retired_cnt_o (retired_cnt_o),
    .taken_cnt_o   (taken_cnt_o),
`endif
    .rs_data_i     (rs_data_i)
  );

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  jump;
    logic        branch;
    logic        btype;
    logic        zero;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    logic        exp_taken;
  } vec_t;

  localparam int NV = 14;
  vec_t        vecs[NV];
  logic [31:0] sb[$];
  int          passed = 0;
  int          total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic scramble_ctrl();
    jump_i        = 2'($urandom);
    branch_i      = 1'($urandom);
    branch_type_i = 1'($urandom);
    zero_i        = 1'($urandom);
    rs_data_i     = $urandom;
  endtask

  // Wait for a fetch request and compare its address with the scoreboard head.
  task automatic wait_fetch(output logic [31:0] exp);
    int n = 0;
    while (!imem_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(imem_req_o), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      exp = 32'hxxxx_xxxx;
    end else begin
      exp = sb.pop_front();
    end
    check("fetch_addr", imem_addr_o, exp);
  endtask

  task automatic fetch_phase(input logic [31:0] data, input int waits);
    logic [31:0] exp;
    wait_fetch(exp);
    for (int w = 0; w < waits; w++) begin
      imem_ack_i    = 1'b0;
      instr_ready_i = 1'b1;
      @(negedge clk);
      check("wait_req", 32'(imem_req_o), 32'd1);
      check("wait_addr", imem_addr_o, exp);
    end
    instr_ready_i = 1'b0;
    imem_ack_i    = 1'b1;
    imem_data_i   = data;
    @(negedge clk);
    imem_ack_i  = 1'b0;
    imem_data_i = $urandom;
    check("valid_up", 32'(instr_valid_o), 32'd1);
    check("req_down", 32'(imem_req_o), 32'd0);
    check("instr", instr_o, data);
    check("pc", pc_o, exp);
    check("pc_plus4", pc_plus4_o, exp + 32'd4);
  endtask

  task automatic hold_accept(input vec_t v);
    imem_ack_i  = 1'b1;
    imem_data_i = ~v.instr;
    @(negedge clk);
    imem_ack_i = 1'b0;
    check("hold_instr", instr_o, v.instr);
    check("hold_pc", pc_o, v.exp_pc);
    check("hold_valid", 32'(instr_valid_o), 32'd1);
    jump_i        = v.jump;
    branch_i      = v.branch;
    branch_type_i = v.btype;
    zero_i        = v.zero;
    rs_data_i     = v.rs;
    instr_ready_i = 1'b1;
    sb.push_back(v.exp_next);
    @(negedge clk);
    instr_ready_i = 1'b0;
    scramble_ctrl();
    check("valid_down", 32'(instr_valid_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp;
    int          n_taken;
    vec_t        seqv;

    //            instr          jump   br  bt  z   rs            pc            next          tk
    vecs[0]  = '{32'h2008_0005, 2'b01, 0, 0, 0, 32'h0,        32'h0,        32'h4,        0};
    vecs[1]  = '{32'h0000_0008, 2'b10, 0, 0, 0, 32'h10,       32'h4,        32'h10,       1};
    vecs[2]  = '{32'h1000_FFFC, 2'b01, 1, 1, 1, 32'h0,        32'h10,       32'h4,        1};
    vecs[3]  = '{32'h0000_0008, 2'b10, 0, 0, 0, 32'h13,       32'h4,        32'h10,       1};
    vecs[4]  = '{32'h1000_FFFC, 2'b01, 1, 1, 0, 32'h0,        32'h10,       32'h14,       0};
    vecs[5]  = '{32'h0000_0008, 2'b10, 0, 0, 0, 32'h10,       32'h14,       32'h10,       1};
    vecs[6]  = '{32'h1400_FFFC, 2'b01, 1, 0, 0, 32'h0,        32'h10,       32'h4,        1};
    vecs[7]  = '{32'h0000_0008, 2'b10, 0, 0, 0, 32'h20,       32'h4,        32'h20,       1};
    vecs[8]  = '{32'h0800_0040, 2'b00, 0, 0, 0, 32'h0,        32'h20,       32'h100,      1};
    vecs[9]  = '{32'h0000_0008, 2'b10, 0, 0, 0, 32'h203,      32'h100,      32'h200,      1};
    vecs[10] = '{32'h0000_0008, 2'b10, 0, 0, 0, 32'hFFFF_FFFC, 32'h200,     32'hFFFF_FFFC, 1};
    vecs[11] = '{32'h0000_0000, 2'b01, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       0};
    vecs[12] = '{32'h0800_0003, 2'b00, 1, 1, 1, 32'h0,        32'h0,        32'hC,        1};
    vecs[13] = '{32'h1000_0001, 2'b11, 1, 1, 1, 32'h0,        32'hC,        32'h14,       1};

    rst_i         = 1'b0;
    imem_ack_i    = 1'b0;
    imem_data_i   = 32'h0;
    instr_ready_i = 1'b0;
    scramble_ctrl();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pc_plus4", pc_plus4_o, 32'h4);
`ifdef FETCH_PERF_EN
    check("rst_retired", retired_cnt_o, 32'h0);
    check("rst_taken", taken_cnt_o, 32'h0);
`endif

    rst_i = 1'b1;
    sb.push_back(32'h0);
    check("idle_req", 32'(imem_req_o), 32'd0);
    @(negedge clk);
    check("first_fetch_req", 32'(imem_req_o), 32'd1);

    n_taken = 0;
    for (int i = 0; i < NV; i++) begin
      fetch_phase(vecs[i].instr, (i == 4) ? 3 : 0);
      hold_accept(vecs[i]);
      if (vecs[i].exp_taken) n_taken++;
    end
`ifdef FETCH_PERF_EN
    check("retired_cnt", retired_cnt_o, 32'(NV));
    check("taken_cnt", taken_cnt_o, 32'(n_taken));
`endif

    // Reset mid-FETCH with an ack in the same cycle: the ack must be dropped.
    wait_fetch(exp);
    imem_ack_i  = 1'b1;
    imem_data_i = 32'hDEAD_BEEF;
    rst_i       = 1'b0;
    #1;
    check("arst_req", 32'(imem_req_o), 32'd0);
    check("arst_valid", 32'(instr_valid_o), 32'd0);
    check("arst_addr", imem_addr_o, 32'h0);
    check("arst_pc_plus4", pc_plus4_o, 32'h4);
`ifdef FETCH_PERF_EN
    check("arst_retired", retired_cnt_o, 32'h0);
    check("arst_taken", taken_cnt_o, 32'h0);
`endif
    @(posedge clk);
    #1;
    check("arst_ack_dropped", instr_o, 32'h0);
    @(negedge clk);
    imem_ack_i = 1'b0;
    rst_i      = 1'b1;
    check("rel_idle_req", 32'(imem_req_o), 32'd0);
    sb.push_back(32'h0);
    @(negedge clk);
    check("rel_fetch_req", 32'(imem_req_o), 32'd1);

    seqv = '{32'h2008_0005, 2'b01, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0};
    fetch_phase(seqv.instr, 3);
    hold_accept(seqv);
    wait_fetch(exp);
`ifdef FETCH_PERF_EN
    check("post_retired", retired_cnt_o, 32'h1);
    check("post_taken", taken_cnt_o, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
